// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with a reset vector, sequential
// increment, prioritised redirects (trap > mret > branch/jump), a fetch
// handshake and a small circular return-address stack.
//
// Handshake: pc_out is a fetch request whenever pc_valid is high. The request
// is consumed on a rising edge where pc_valid && fetch_ready, and the PC then
// advances by INC. Without fetch_ready (or while stall is high) pc_out holds
// steady. Redirects take effect on the next edge regardless of fetch_ready or
// stall, so a redirect is never lost.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            misaligned,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty
);

    localparam int                PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [XLEN-1:0]   INC_W   = XLEN'(INC);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]    CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

    // BOOT is a single dead cycle after reset; RUN lasts until the next reset.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    logic            sel_valid;
    logic [XLEN-1:0] sel_target;

    // Highest-priority redirect source this cycle, if any.
    always_comb begin
        sel_valid  = 1'b1;
        sel_target = '0;
        if (trap_valid) begin
            sel_target = trap_vector;
        end else if (mret_valid) begin
            sel_target = mepc;
        end else if (redirect_valid) begin
            sel_target = redirect_pc;
        end else begin
            sel_valid = 1'b0;
        end
    end

    // PC state machine: BOOT holds the reset vector, RUN picks the next PC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= BOOT;
            pc_out     <= RESET_VECTOR;
            pc_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid   <= 1'b1;
                    misaligned <= 1'b0;
                end
                RUN: begin
                    pc_valid <= 1'b1;
                    if (sel_valid) begin
                        // Targets are word aligned; low bits only raise the flag.
                        pc_out     <= {sel_target[XLEN-1:2], 2'b00};
                        misaligned <= |sel_target[1:0];
                    end else begin
                        misaligned <= 1'b0;
                        if (!stall && fetch_ready) begin
                            pc_out <= pc_out + INC_W;
                        end
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_cnt;

    // Return-address stack: circular buffer, oldest entry lost on overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (ras_push && ras_pop && (ras_cnt != '0)) begin
            ras_mem[ras_ptr] <= ras_push_addr;
        end else if (ras_push) begin
            ras_mem[ras_ptr + PTR_ONE] <= ras_push_addr;
            ras_ptr                    <= ras_ptr + PTR_ONE;
            if (ras_cnt != CNT_MAX) begin
                ras_cnt <= ras_cnt + CNT_ONE;
            end
        end else if (ras_pop && (ras_cnt != '0)) begin
            ras_ptr <= ras_ptr - PTR_ONE;
            ras_cnt <= ras_cnt - CNT_ONE;
        end
    end

    assign ras_empty = (ras_cnt == '0);
    assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr];

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed walk through the fetch/redirect/RAS scenarios followed
// by randomized traffic, all checked against a queue-based reference model.
module tb_pc_unit;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  logic        fetch_ready, stall, redirect_valid, trap_valid, mret_valid;
  logic        ras_push, ras_pop;
  logic [31:0] redirect_pc, trap_vector, mepc, ras_push_addr;
  logic [31:0] pc_out, ras_top;
  logic        pc_valid, misaligned, ras_empty;

  pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(RV),
    .INC(4),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .fetch_ready(fetch_ready),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .trap_valid(trap_valid),
    .trap_vector(trap_vector),
    .mret_valid(mret_valid),
    .mepc(mepc),
    .ras_push(ras_push),
    .ras_push_addr(ras_push_addr),
    .ras_pop(ras_pop),
    .pc_out(pc_out),
    .pc_valid(pc_valid),
    .misaligned(misaligned),
    .ras_top(ras_top),
    .ras_empty(ras_empty)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] m_pc;
  bit          m_run;
  bit          m_mis;
  logic [31:0] ras_q[$];   // back of queue = top of stack

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = RV;
    m_run = 0;
    m_mis = 0;
    ras_q.delete();
  endtask

  // What one rising edge should do, given the inputs currently applied.
  task automatic model_edge();
    logic [31:0] tgt;
    bit          sel;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (!m_run) begin
      m_run = 1;
      m_mis = 0;
    end else begin
      sel = 1;
      tgt = 32'h0;
      if (trap_valid)          tgt = trap_vector;
      else if (mret_valid)     tgt = mepc;
      else if (redirect_valid) tgt = redirect_pc;
      else                     sel = 0;
      if (sel) begin
        m_pc  = tgt & 32'hFFFF_FFFC;
        m_mis = (tgt % 4) != 0;
      end else begin
        m_mis = 0;
        if (!stall && fetch_ready) m_pc = m_pc + 32'd4;
      end
    end
    if (ras_push && ras_pop && ras_q.size() > 0) begin
      ras_q[ras_q.size()-1] = ras_push_addr;
    end else if (ras_push) begin
      ras_q.push_back(ras_push_addr);
      if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
    end else if (ras_pop && ras_q.size() > 0) begin
      void'(ras_q.pop_back());
    end
  endtask

  function automatic logic [31:0] exp_top();
    if (ras_q.size() == 0) return 32'h0;
    return ras_q[ras_q.size()-1];
  endfunction

  task automatic compare_all(input string ph);
    chk({ph, ".pc_out"},     pc_out,              m_pc);
    chk({ph, ".pc_valid"},   32'(pc_valid),       32'(m_run));
    chk({ph, ".misaligned"}, 32'(misaligned),     32'(m_mis));
    chk({ph, ".ras_top"},    ras_top,             exp_top());
    chk({ph, ".ras_empty"},  32'(ras_empty),      32'(ras_q.size() == 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_in();
    fetch_ready = 0; stall = 0; redirect_valid = 0; trap_valid = 0; mret_valid = 0;
    ras_push = 0; ras_pop = 0;
    redirect_pc = 0; trap_vector = 0; mepc = 0; ras_push_addr = 0;
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ph);
  endtask

  task automatic ras_op(input bit push, input bit pop, input logic [31:0] addr);
    ras_push = push; ras_pop = pop; ras_push_addr = addr;
    step("ras");
    ras_push = 0; ras_pop = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    clr_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rstn = 1;
    #1;
    chk("tp1.boot_valid", 32'(pc_valid), 32'h0);
    chk("tp1.boot_pc", pc_out, 32'h100);

    // tp1: boot cycle then sequential fetch
    fetch_ready = 1;
    step("tp1"); chk("tp1.pc0", pc_out, 32'h100); chk("tp1.valid", 32'(pc_valid), 32'h1);
    step("tp1"); chk("tp1.pc1", pc_out, 32'h104);
    step("tp1"); chk("tp1.pc2", pc_out, 32'h108);

    // tp2: stall and fetch_ready holds
    redirect_valid = 1; redirect_pc = 32'h200;
    step("tp2"); chk("tp2.redir", pc_out, 32'h200);
    redirect_valid = 0; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step("tp2"); chk("tp2.stall", pc_out, 32'h200);
    end
    stall = 0;
    step("tp2"); chk("tp2.resume", pc_out, 32'h204);
    fetch_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step("tp2"); chk("tp2.noready", pc_out, 32'h204);
    end

    // tp3: priority among redirect sources
    trap_valid = 1; trap_vector = 32'h800;
    mret_valid = 1; mepc = 32'h300;
    redirect_valid = 1; redirect_pc = 32'h400; stall = 1;
    step("tp3"); chk("tp3.trap", pc_out, 32'h800);
    trap_valid = 0;
    step("tp3"); chk("tp3.mret", pc_out, 32'h300);
    clr_in();

    // tp4: misaligned target and increment wrap
    redirect_valid = 1; redirect_pc = 32'h0000_0402;
    step("tp4"); chk("tp4.align", pc_out, 32'h400); chk("tp4.mis1", 32'(misaligned), 32'h1);
    redirect_valid = 0;
    step("tp4"); chk("tp4.mis0", 32'(misaligned), 32'h0);
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step("tp4");
    redirect_valid = 0; fetch_ready = 1;
    step("tp4"); chk("tp4.wrap", pc_out, 32'h0); chk("tp4.wrap_mis", 32'(misaligned), 32'h0);
    clr_in();

    // tp5: RAS overflow, ordered pops, underflow, push+pop replace
    ras_op(1, 0, 32'hA0); ras_op(1, 0, 32'hB0); ras_op(1, 0, 32'hC0);
    ras_op(1, 0, 32'hD0); ras_op(1, 0, 32'hE0);
    chk("tp5.top_e", ras_top, 32'hE0);
    ras_op(0, 1, 0); chk("tp5.pop_d", ras_top, 32'hD0);
    ras_op(0, 1, 0); chk("tp5.pop_c", ras_top, 32'hC0);
    ras_op(0, 1, 0); chk("tp5.pop_b", ras_top, 32'hB0);
    ras_op(0, 1, 0); chk("tp5.empty", 32'(ras_empty), 32'h1);
    ras_op(0, 1, 0); chk("tp5.under", ras_top, 32'h0);
    ras_op(1, 0, 32'h1110);
    ras_op(1, 1, 32'h2220); chk("tp5.replace", ras_top, 32'h2220);
    ras_op(0, 1, 0); chk("tp5.cnt_same", 32'(ras_empty), 32'h1);
    ras_op(1, 1, 32'h3330); chk("tp5.pushpop_empty", ras_top, 32'h3330);

    // tp6: asynchronous reset mid-cycle during a push and a redirect
    ras_push = 1; ras_push_addr = 32'h4440; redirect_valid = 1; redirect_pc = 32'h900;
    #2 rstn = 0;
    #1;
    model_reset();
    compare_all("tp6");
    chk("tp6.pc", pc_out, RV);
    step("tp6.hold");
    clr_in();
    rstn = 1;

    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 400; c++) begin
      fetch_ready    = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      trap_valid     = ($urandom_range(0, 15) == 0);
      mret_valid     = ($urandom_range(0, 11) == 0);
      redirect_valid = ($urandom_range(0, 5) == 0);
      trap_vector    = rand_addr();
      mepc           = rand_addr();
      redirect_pc    = rand_addr();
      ras_push       = ($urandom_range(0, 2) == 0);
      ras_pop        = ($urandom_range(0, 2) == 0);
      ras_push_addr  = rand_addr();
      if ($urandom_range(0, 99) == 0) begin
        #2 rstn = 0;
        #1;
        model_reset();
        compare_all("rnd.areset");
        step("rnd.hold");
        rstn = 1;
      end else begin
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
